scan_decoder: RTL and testbench
===============================

Name: scan_decoder

Overview:
Parametrised successor to the team's fixed 3-to-8 one-hot decoder. It takes an SEL_W-bit index and drives a registered one-hot output of 2^SEL_W lines. It has two modes:
- Direct: load an index.
- Scan: auto-step through all lines with a programmable dwell, wrapping around.

Typical uses are row/digit select for multiplexed displays and round-robin channel strobes.

Parameters:
SEL_W, 3, index width; output width OUT_W = 2^SEL_W (derived localparam, not overridable)
DWELL, 4, clock cycles each line stays asserted in scan mode; legal range 1..65535

Ports:
clk     in   1      clock, all logic on rising edge
rst_n   in   1      synchronous active-low reset, sampled on rising edge of clk
en      in   1      block enable; 0 forces IDLE
mode    in   1      0 = direct, 1 = scan
load    in   1      load sel_in into index (both modes)
sel_in  in   SEL_W  index to load
y       out  OUT_W  registered one-hot select lines
idx     out  SEL_W  current index register
wrap    out  1      one-cycle pulse when scan wraps from OUT_W-1 to 0
active  out  1      1 when in DIRECT or SCAN state

Behaviour:
- One clock; reset is synchronous and active-low: rst_n low at a rising edge of clk resets the block.
- Reset values: y=0, idx=0, wrap=0, active=0, dwell counter=0, state=IDLE.
- Reset mid-operation takes effect at the next edge. It overrides en and load.
- All outputs are registered. Output latency from a sampled input to y/idx is 1 cycle.
- Invariant: y == one-hot(idx) whenever active=1; y == 0 whenever active=0.
- The dwell counter is $clog2(DWELL+1) bits wide and counts 0..DWELL-1.
- idx arithmetic is modulo 2^SEL_W, giving natural wrap.
- States: IDLE, DIRECT, SCAN.
- IDLE:
  - y=0, active=0, idx holds its value.
  - en=1, mode=0 -> DIRECT.
  - en=1, mode=1 -> SCAN with idx<=0 and counter<=0.
  - If load=1 on the entry cycle, idx<=sel_in instead of 0.
- DIRECT:
  - load=1 -> idx<=sel_in; otherwise hold.
  - The counter is held at 0.
  - en=1, mode=1 -> SCAN, starting from current idx (or sel_in if load=1), counter<=0.
- SCAN:
  - The counter increments each cycle.
  - When counter==DWELL-1: counter<=0 and idx<=idx+1.
  - If idx was OUT_W-1, idx<=0 and wrap<=1 for exactly that next cycle. wrap is coincident with y showing line 0.
  - DWELL=1 steps every cycle.
- load in SCAN: idx<=sel_in and counter<=0. load has priority over a same-cycle step, and no wrap pulse is generated.
- SCAN -> DIRECT (mode=0): idx holds its current value and the counter clears.
- en=0 in any state -> IDLE next cycle. y=0, active=0, wrap=0, idx retained, counter cleared.
- wrap is 0 in every state other than on the scan step described above.
- sel_in is only sampled when load=1.

Optional Feature:
Macro ACTIVE_LOW_OUT_EN.
- Defined: the y port is the bitwise inverse of the internal one-hot register. The reset/IDLE value is all-ones, and the asserted line is 0. This suits common-anode displays.
- Not defined: y is active-high as described above.
- idx, wrap and active are unaffected either way.
- The inversion must be applied to the registered value, so latency is unchanged.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with en=1, load=1, sel_in=5 -> y=8'h00, idx=0, wrap=0, active=0 throughout.
2. Direct load: en=1, mode=0, then load=1, sel_in=3 -> 1 cycle later y=8'h08, idx=3. Then load=1, sel_in=7 -> y=8'h80. With load=0 for 10 cycles -> y holds 8'h80.
3. Scan with DWELL=4 from IDLE (en rises, mode=1):
   - y=8'h01 for 4 cycles, then 8'h02, ... 8'h80.
   - Then y=8'h01 with wrap=1 for exactly 1 cycle.
   - Full period is 32 cycles.
4. Load during scan: at idx=2 with counter=1, load=1, sel_in=6 -> next cycle y=8'h40, and it dwells a full 4 cycles. A load with sel_in=0 on the step cycle from idx=7 -> idx=0 and wrap=0.
5. Disable and mode switch:
   - en=0 mid-scan at idx=5 -> next cycle y=0, active=0, idx=5.
   - Then en=1, mode=0 -> y=8'h20.
   - Then mode=1 -> scan resumes from 5, next step to 6 after 4 cycles.
   - Synchronous reset mid-scan -> all outputs reset on the next edge.
6. Parameter sweep:
   - SEL_W=4, DWELL=1 -> y steps 16'h0001..16'h8000 every cycle, wrap every 16 cycles.
   - ACTIVE_LOW_OUT_EN defined, SEL_W=3 -> y=8'hFF in IDLE and 8'hFE at idx=0.

Source files
------------

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot select with direct-load and auto-scan modes.
// Optional build macro ACTIVE_LOW_OUT_EN inverts the y port (common-anode drive).
module scan_decoder #(
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  load,
    input  logic [SEL_W-1:0]      sel_in,
    output logic [(1<<SEL_W)-1:0] y,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap,
    output logic                  active
);

    localparam int OUT_W = 1 << SEL_W;
    localparam int CNT_W = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIRECT,
        S_SCAN
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   oh_q, oh_d;
    logic               wrap_q, wrap_d;
    logic               active_q, active_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            oh_q     <= '0;
            wrap_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            oh_q     <= oh_d;
            wrap_q   <= wrap_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (mode) begin
                        state_d = S_SCAN;
                        idx_d   = load ? sel_in : '0;
                    end else begin
                        state_d = S_DIRECT;
                        if (load) idx_d = sel_in;
                    end
                end
                S_DIRECT: begin
                    cnt_d = '0;
                    if (load) idx_d = sel_in;
                    if (mode) state_d = S_SCAN;
                end
                S_SCAN: begin
                    if (!mode) begin
                        state_d = S_DIRECT;
                        cnt_d   = '0;
                        if (load) idx_d = sel_in;
                    end else if (load) begin
                        // a load beats a same-cycle step and never pulses wrap
                        idx_d = sel_in;
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        idx_d  = idx_q + 1'b1;
                        wrap_d = &idx_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        active_d = (state_d != S_IDLE);
        oh_d     = active_d ? (OUT_W'(1) << idx_d) : '0;
    end

`ifdef ACTIVE_LOW_OUT_EN
    assign y = ~oh_q;
`else
    assign y = oh_q;
`endif
    assign idx    = idx_q;
    assign wrap   = wrap_q;
    assign active = active_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed self-checking bench for scan_decoder (3/4 and 4/1 configurations).
// Expected y polarity follows ACTIVE_LOW_OUT_EN when the bench is built with it.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n, en, mode, load;
    logic [2:0] sel_in;
    logic [7:0] y;
    logic [2:0] idx;
    logic       wrap, active;

    logic        en2, mode2, load2;
    logic [3:0]  sel2;
    logic [15:0] y2;
    logic [3:0]  idx2;
    logic        wrap2, active2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(3), .DWELL(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .sel_in(sel_in), .y(y), .idx(idx), .wrap(wrap), .active(active)
    );

    scan_decoder #(.SEL_W(4), .DWELL(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .load(load2),
        .sel_in(sel2), .y(y2), .idx(idx2), .wrap(wrap2), .active(active2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ey(input int i, input bit act);
        logic [7:0] v;
        v = act ? 8'(1 << i) : 8'h00;
`ifdef ACTIVE_LOW_OUT_EN
        v = ~v;
`endif
        return v;
    endfunction

    function automatic logic [15:0] ey2(input int i, input bit act);
        logic [15:0] v;
        v = act ? 16'(1 << i) : 16'h0000;
`ifdef ACTIVE_LOW_OUT_EN
        v = ~v;
`endif
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 1'b0; load = 1'b1; sel_in = 3'd5;
        en2 = 1'b0; mode2 = 1'b1; load2 = 1'b0; sel2 = 4'd0;
        #2;

        // reset held with en/load asserted
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_y", y, ey(0, 0));
            check("rst_idx", idx, 3'd0);
            check("rst_wrap", wrap, 1'b0);
            check("rst_active", active, 1'b0);
        end

        // direct mode
        rst_n = 1'b1; load = 1'b0;
        step();
        check("dir_entry_active", active, 1'b1);
        check("dir_entry_y", y, ey(0, 1));
        load = 1'b1; sel_in = 3'd3;
        step();
        check("dir_load3_y", y, ey(3, 1));
        check("dir_load3_idx", idx, 3'd3);
        sel_in = 3'd7;
        step();
        check("dir_load7_y", y, ey(7, 1));
        load = 1'b0; sel_in = 3'd1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("dir_hold_y", y, ey(7, 1));
        end

        // idle then scan from idle, full period plus wrap
        en = 1'b0;
        step();
        check("idle_y", y, ey(0, 0));
        check("idle_active", active, 1'b0);
        check("idle_idx", idx, 3'd7);
        en = 1'b1; mode = 1'b1;
        for (int k = 0; k <= 33; k++) begin
            step();
            check("scan_y", y, ey((k / 4) % 8, 1));
            check("scan_wrap", wrap, (k == 32) ? 1'b1 : 1'b0);
        end

        // now idx=0 cnt=1; advance to idx=2 cnt=1
        steps(8);
        check("pre_load_idx", idx, 3'd2);
        load = 1'b1; sel_in = 3'd6;
        step();
        check("scan_load_y", y, ey(6, 1));
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("scan_load_dwell", y, ey(6, 1));
        end
        step();
        check("scan_after_load_y", y, ey(7, 1));
        steps(3);
        load = 1'b1; sel_in = 3'd0;
        step();
        check("load_on_step_idx", idx, 3'd0);
        check("load_on_step_wrap", wrap, 1'b0);
        check("load_on_step_y", y, ey(0, 1));
        load = 1'b0;

        // disable mid-scan at idx 5, direct, then resume scan
        steps(20);
        check("pre_dis_idx", idx, 3'd5);
        en = 1'b0;
        step();
        check("dis_y", y, ey(0, 0));
        check("dis_active", active, 1'b0);
        check("dis_idx", idx, 3'd5);
        en = 1'b1; mode = 1'b0;
        step();
        check("redir_y", y, ey(5, 1));
        mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("resume_dwell_y", y, ey(5, 1));
        end
        step();
        check("resume_step_y", y, ey(6, 1));

        // synchronous reset mid-scan
        rst_n = 1'b0;
        step();
        check("mid_rst_y", y, ey(0, 0));
        check("mid_rst_idx", idx, 3'd0);
        check("mid_rst_wrap", wrap, 1'b0);
        check("mid_rst_active", active, 1'b0);
        rst_n = 1'b1; en = 1'b0;

        // 16 lines, single-cycle dwell
        step();
        check("w16_idle_y", y2, ey2(0, 0));
        en2 = 1'b1;
        for (int k = 0; k <= 33; k++) begin
            step();
            check("w16_y", y2, ey2(k % 16, 1));
            check("w16_wrap", wrap2, (k == 16 || k == 32) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
